// File: rtl/digi_pkg.sv
// Shared types and constants for the digitizer readout scheduler.
package digi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        DRAIN = 3'd3,
        TRL   = 3'd4,
        CLR   = 3'd5
    } state_t;

    localparam logic HDR_MARK = 1'b0;
    localparam logic TRL_MARK = 1'b1;
    localparam int   BC_W     = 12;
    localparam int   CH_W     = 3;

    // Saturating add used by the dropped-trigger counter.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/ro_scheduler_if.sv
// Channel-buffer and FIFO-side signals of the readout scheduler, plus a state debug tap.
interface ro_scheduler_if #(
    parameter int CHAN  = 8,
    parameter int WIDTH = 16,
    parameter int SIZE  = 8
);
    import digi_pkg::*;

    logic [CHAN-1:0]       TRIGGER;
    logic [SIZE-1:0]       howmany;
    logic [BC_W-1:0]       BC;
    logic [WIDTH*CHAN-1:0] CH_DATA;
    logic                  FIFO_AFULL;
    logic [CHAN-1:0]       RD_REQUEST;
    logic [WIDTH-1:0]      FIFO_DIN;
    logic                  FIFO_WR_EN;
    logic [CH_W-1:0]       CUR_CHAN;
    logic                  BUSY;
    logic [7:0]            DROP_CNT;
    state_t                STATE;

    // RD_REQUEST is a single-cycle read strobe and the buffer answers on CH_DATA the next cycle;
    // FIFO_WR_EN qualifies FIFO_DIN, and FIFO_AFULL low (4+ free words) is the only ready condition.
    modport master (
        output TRIGGER, howmany, BC, CH_DATA, FIFO_AFULL,
        input  RD_REQUEST, FIFO_DIN, FIFO_WR_EN, CUR_CHAN, BUSY, DROP_CNT, STATE
    );

    modport slave (
        input  TRIGGER, howmany, BC, CH_DATA, FIFO_AFULL,
        output RD_REQUEST, FIFO_DIN, FIFO_WR_EN, CUR_CHAN, BUSY, DROP_CNT, STATE
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester strictly above 'last', wrapping modulo CHAN.
module rr_arbiter #(
    parameter int CHAN = 8
) (
    input  logic [CHAN-1:0] req,
    input  logic [2:0]      last,
    output logic [2:0]      gnt_idx,
    output logic            gnt_valid
);

    function automatic int wrap_idx(input logic [2:0] base, input int k);
        return (int'(base) + 1 + k) % CHAN;
    endfunction

    // Walk from the farthest position down so the nearest requester is assigned last and wins.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = CHAN - 1; k >= 0; k--) begin
            if (req[wrap_idx(last, k)]) begin
                gnt_idx   = 3'(wrap_idx(last, k));
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ro_scheduler.sv
// ro_scheduler: round-robin readout of triggered channel buffers into the global FIFO.
// Define RO_TRAILER_EN to append a trailer word {1, chan, 4'b0, howmany} after each burst.
module ro_scheduler
    import digi_pkg::*;
#(
    parameter int CHAN  = 8,
    parameter int WIDTH = 16,
    parameter int SIZE  = 8
) (
    input logic           CLK,
    input logic           RST,
    ro_scheduler_if.slave bus
);

    state_t          state_q, state_d;
    logic [CHAN-1:0] pend_q, pend_d;
    logic [CH_W-1:0] last_q, last_d;
    logic [CH_W-1:0] cur_q, cur_d;
    logic [BC_W-1:0] bc_q, bc_d;
    logic [SIZE-1:0] cnt_q, cnt_d;
    logic [CHAN-1:0] req_q, req_d;
    logic            rd_d1_q;
    logic [WIDTH-1:0] din_q, din_d;
    logic            wr_q, wr_d;
    logic [7:0]      drop_q, drop_d;
    logic            drain_q, drain_d;
`ifdef RO_TRAILER_EN
    logic [SIZE-1:0] hm_q, hm_d;
    localparam state_t BODY_DONE = TRL;
`else
    localparam state_t BODY_DONE = CLR;
`endif

    logic [CHAN-1:0] chan_mask;
    logic [CHAN-1:0] clr_mask;
    logic [CHAN-1:0] drops;
    logic [CH_W-1:0] gnt_idx;
    logic            gnt_valid;

    rr_arbiter #(.CHAN(CHAN)) u_arb (
        .req       (pend_q),
        .last      (last_q),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign chan_mask = CHAN'(1) << cur_q;
    assign clr_mask  = (state_q == CLR) ? chan_mask : '0;

    // A trigger landing on the clearing cycle re-arms the bit instead of counting as a drop.
    assign drops  = bus.TRIGGER & pend_q & ~clr_mask;
    assign pend_d = (pend_q & ~clr_mask) | bus.TRIGGER;
    assign drop_d = sat_add8(drop_q, 4'($countones(drops)));

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cur_d   = cur_q;
        bc_d    = bc_q;
        cnt_d   = cnt_q;
        req_d   = '0;
        din_d   = din_q;
        wr_d    = 1'b0;
        drain_d = drain_q;
`ifdef RO_TRAILER_EN
        hm_d    = hm_q;
`endif

        if (rd_d1_q) begin
            din_d = bus.CH_DATA[int'(cur_q)*WIDTH +: WIDTH];
            wr_d  = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    cur_d   = gnt_idx;
                    bc_d    = bus.BC;
                    cnt_d   = bus.howmany;
`ifdef RO_TRAILER_EN
                    hm_d    = bus.howmany;
`endif
                    state_d = HDR;
                end
            end
            HDR: begin
                // The first read goes out with the header so requests start in the header's write cycle.
                if (!bus.FIFO_AFULL) begin
                    din_d = {HDR_MARK, cur_q, bc_q};
                    wr_d  = 1'b1;
                    if (cnt_q != '0) begin
                        req_d   = chan_mask;
                        cnt_d   = cnt_q - SIZE'(1);
                        drain_d = 1'b0;
                        state_d = (cnt_q == SIZE'(1)) ? DRAIN : DATA;
                    end else begin
                        state_d = BODY_DONE;
                    end
                end
            end
            DATA: begin
                if (!bus.FIFO_AFULL) begin
                    req_d = chan_mask;
                    cnt_d = cnt_q - SIZE'(1);
                    if (cnt_q == SIZE'(1)) begin
                        drain_d = 1'b0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Two quiet cycles once the request and buffer-delay stages are empty.
                if (req_q == '0 && !rd_d1_q) begin
                    drain_d = 1'b1;
                    if (drain_q) begin
                        state_d = BODY_DONE;
                    end
                end
            end
`ifdef RO_TRAILER_EN
            TRL: begin
                if (!bus.FIFO_AFULL) begin
                    din_d   = {TRL_MARK, cur_q, 4'b0000, 8'(hm_q)};
                    wr_d    = 1'b1;
                    state_d = CLR;
                end
            end
`endif
            CLR: begin
                last_d  = cur_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            pend_q  <= '0;
            last_q  <= 3'(CHAN - 1);
            cur_q   <= '0;
            bc_q    <= '0;
            cnt_q   <= '0;
            req_q   <= '0;
            rd_d1_q <= 1'b0;
            din_q   <= '0;
            wr_q    <= 1'b0;
            drop_q  <= '0;
            drain_q <= 1'b0;
`ifdef RO_TRAILER_EN
            hm_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
            bc_q    <= bc_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rd_d1_q <= |req_q;
            din_q   <= din_d;
            wr_q    <= wr_d;
            drop_q  <= drop_d;
            drain_q <= drain_d;
`ifdef RO_TRAILER_EN
            hm_q    <= hm_d;
`endif
        end
    end

    assign bus.RD_REQUEST = req_q;
    assign bus.FIFO_DIN   = din_q;
    assign bus.FIFO_WR_EN = wr_q;
    assign bus.CUR_CHAN   = cur_q;
    assign bus.BUSY       = (state_q != IDLE);
    assign bus.DROP_CNT   = drop_q;
    assign bus.STATE      = state_q;

endmodule

// File: tb/tb_ro_scheduler.sv
// Directed self-checking bench for ro_scheduler: buffer model, FIFO monitor and cycle-exact checks.
module tb_ro_scheduler;
  import digi_pkg::*;

  logic CLK;
  logic RST;
  int checks;
  int failures;

  ro_scheduler_if bus ();

  ro_scheduler u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          req_cycles[8];
  int          rd_cnt[8];
  int          nxt[8];
  int          onehot_viol;
  logic [7:0]  req_snap;

  function automatic logic [15:0] sample_word(input int ch, input int k);
    return 16'hD000 | 16'((ch & 7) << 8) | 16'(k & 255);
  endfunction

  // FIFO monitor and request observer, sampled mid-cycle
  always @(negedge CLK) begin
    req_snap = bus.RD_REQUEST;
    if (bus.FIFO_WR_EN) got_q.push_back(bus.FIFO_DIN);
    if ($countones(bus.RD_REQUEST) > 1) onehot_viol++;
    for (int i = 0; i < 8; i++) begin
      if (bus.RD_REQUEST[i]) req_cycles[i]++;
    end
  end

  // channel buffer model: data appears the cycle after a request
  always @(posedge CLK) begin
    #1;
    for (int i = 0; i < 8; i++) begin
      if (req_snap[i]) begin
        bus.CH_DATA[i*16 +: 16] = sample_word(i, rd_cnt[i]);
        rd_cnt[i]++;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();
  endtask

  task automatic push_data(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(sample_word(ch, nxt[ch]));
      nxt[ch]++;
    end
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int cyc;
    cyc = 0;
    while (got_q.size() < n && cyc < budget) begin
      tick();
      cyc++;
    end
    chk({tag, "_words_in_time"}, 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic check_words(input string tag);
    logic [31:0] obs;
    chk({tag, "_word_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      obs = (k < got_q.size()) ? 32'(got_q[k]) : 32'hDEAD_BEEF;
      chk($sformatf("%s_word%0d", tag, k), obs, 32'(exp_q[k]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    onehot_viol = 0;
    for (int i = 0; i < 8; i++) begin
      req_cycles[i] = 0;
      rd_cnt[i] = 0;
      nxt[i] = 0;
    end
    RST = 1'b0;
    bus.TRIGGER = '0;
    bus.howmany = '0;
    bus.BC = '0;
    bus.FIFO_AFULL = 1'b0;
    repeat (3) tick();

    // reset state
    chk("rst_req", 32'(bus.RD_REQUEST), 32'h0);
    chk("rst_wr", 32'(bus.FIFO_WR_EN), 32'h0);
    chk("rst_din", 32'(bus.FIFO_DIN), 32'h0);
    chk("rst_cur", 32'(bus.CUR_CHAN), 32'h0);
    chk("rst_busy", 32'(bus.BUSY), 32'h0);
    chk("rst_drop", 32'(bus.DROP_CNT), 32'h0);
    RST = 1'b1;
    tick();

    // single trigger on ch2, 4 samples, cycle-exact
    bus.howmany = 8'd4;
    bus.BC = 12'h123;
    bus.TRIGGER = 8'h04;
    tick();
    bus.TRIGGER = '0;
    chk("s1_c1_busy", 32'(bus.BUSY), 32'h0);
    tick();
    chk("s1_c2_busy", 32'(bus.BUSY), 32'h1);
    chk("s1_c2_wr", 32'(bus.FIFO_WR_EN), 32'h0);
    tick();
    chk("s1_c3_wr", 32'(bus.FIFO_WR_EN), 32'h1);
    chk("s1_c3_hdr", 32'(bus.FIFO_DIN), 32'h2123);
    chk("s1_c3_req", 32'(bus.RD_REQUEST), 32'h04);
    chk("s1_c3_cur", 32'(bus.CUR_CHAN), 32'h2);
    repeat (7) tick();
    chk("s1_c10_busy", 32'(bus.BUSY), 32'h1);
    tick();
    chk("s1_c11_idle", 32'(bus.BUSY), 32'h0);
    exp_q.push_back(16'h2123);
    push_data(2, 4);
    check_words("s1");
    chk("s1_req_cycles", 32'(req_cycles[2]), 32'd4);

    // simultaneous triggers right after reset: order ch0, ch2, ch7
    do_reset();
    bus.howmany = 8'd2;
    bus.BC = 12'h0AB;
    bus.TRIGGER = 8'b1000_0101;
    tick();
    bus.TRIGGER = '0;
    exp_q.push_back(16'h00AB);
    push_data(0, 2);
    exp_q.push_back(16'h20AB);
    push_data(2, 2);
    exp_q.push_back(16'h70AB);
    push_data(7, 2);
    wait_words("s2", 9, 200);
    repeat (10) tick();
    chk("s2_idle", 32'(bus.BUSY), 32'h0);
    check_words("s2");
    chk("s2_drop", 32'(bus.DROP_CNT), 32'h0);

    // back-pressure: 10 cycles of almost-full mid-DATA on ch5
    bus.howmany = 8'd16;
    bus.BC = 12'h3C5;
    bus.TRIGGER = 8'h20;
    tick();
    bus.TRIGGER = '0;
    repeat (4) tick();
    chk("s3_pre_stall_req", 32'(bus.RD_REQUEST), 32'h20);
    bus.FIFO_AFULL = 1'b1;
    begin
      int stall_reqs;
      stall_reqs = 0;
      for (int j = 0; j < 10; j++) begin
        tick();
        if (bus.RD_REQUEST != '0) stall_reqs++;
      end
      bus.FIFO_AFULL = 1'b0;
      chk("s3_stall_req", 32'(stall_reqs), 32'd0);
    end
    tick();
    chk("s3_resume_req", 32'(bus.RD_REQUEST), 32'h20);
    exp_q.push_back(16'h53C5);
    push_data(5, 16);
    wait_words("s3", 17, 300);
    repeat (8) tick();
    check_words("s3");
    chk("s3_req_cycles", 32'(req_cycles[5]), 32'd16);
    chk("s3_idle", 32'(bus.BUSY), 32'h0);

    // drop during own burst, re-arm in the clearing cycle
    bus.howmany = 8'd4;
    bus.BC = 12'h011;
    bus.TRIGGER = 8'h02;
    tick();
    bus.TRIGGER = '0;
    repeat (3) tick();
    bus.TRIGGER = 8'h02;
    tick();
    bus.TRIGGER = '0;
    chk("s4_drop_burst", 32'(bus.DROP_CNT), 32'd1);
    repeat (5) tick();
    chk("s4_c10_clr", 32'(bus.STATE), 32'(CLR));
    bus.TRIGGER = 8'h02;
    bus.howmany = 8'd1;
    bus.BC = 12'h022;
    tick();
    bus.TRIGGER = '0;
    chk("s4_drop_clr", 32'(bus.DROP_CNT), 32'd1);
    exp_q.push_back(16'h1011);
    push_data(1, 4);
    exp_q.push_back(16'h1022);
    push_data(1, 1);
    wait_words("s4", 7, 200);
    repeat (10) tick();
    check_words("s4");
    chk("s4_req_cycles", 32'(req_cycles[1]), 32'd5);
    chk("s4_idle", 32'(bus.BUSY), 32'h0);

    // zero samples on ch6, header held off by almost-full
    bus.howmany = 8'd0;
    bus.BC = 12'h456;
    bus.FIFO_AFULL = 1'b1;
    bus.TRIGGER = 8'h40;
    tick();
    bus.TRIGGER = '0;
    tick();
    tick();
    chk("s5_c3_hold", 32'(bus.FIFO_WR_EN), 32'h0);
    tick();
    chk("s5_c4_hold", 32'(bus.FIFO_WR_EN), 32'h0);
    bus.FIFO_AFULL = 1'b0;
    tick();
    chk("s5_c5_wr", 32'(bus.FIFO_WR_EN), 32'h1);
    chk("s5_c5_hdr", 32'(bus.FIFO_DIN), 32'h6456);
    chk("s5_c5_req", 32'(bus.RD_REQUEST), 32'h0);
    tick();
    tick();
    chk("s5_c7_idle", 32'(bus.BUSY), 32'h0);
    exp_q.push_back(16'h6456);
`ifdef RO_TRAILER_EN
    exp_q.push_back(16'hE000);
`endif
    repeat (3) tick();
    check_words("s5");
    chk("s5_req_cycles", 32'(req_cycles[6]), 32'd0);

    // reset in the middle of a ch3 burst
    bus.howmany = 8'd8;
    bus.BC = 12'h789;
    bus.TRIGGER = 8'h08;
    tick();
    bus.TRIGGER = '0;
    repeat (4) tick();
    chk("s6_pre_rst_req", 32'(bus.RD_REQUEST), 32'h08);
    chk("s6_pre_rst_wr", 32'(bus.FIFO_WR_EN), 32'h1);
    RST = 1'b0;
    #1;
    chk("s6_rst_req", 32'(bus.RD_REQUEST), 32'h0);
    chk("s6_rst_wr", 32'(bus.FIFO_WR_EN), 32'h0);
    chk("s6_rst_din", 32'(bus.FIFO_DIN), 32'h0);
    chk("s6_rst_cur", 32'(bus.CUR_CHAN), 32'h0);
    chk("s6_rst_busy", 32'(bus.BUSY), 32'h0);
    chk("s6_rst_drop", 32'(bus.DROP_CNT), 32'h0);
    tick();
    tick();
    RST = 1'b1;
    tick();
    chk("s6_post_idle", 32'(bus.BUSY), 32'h0);
    chk("s6_post_state", 32'(bus.STATE), 32'(IDLE));
    // header written before the abort, and two reads already consumed from ch3
    exp_q.push_back(16'h3789);
    nxt[3] += 2;
    bus.howmany = 8'd2;
    bus.BC = 12'h0F0;
    bus.TRIGGER = 8'h08;
    tick();
    bus.TRIGGER = '0;
    exp_q.push_back(16'h30F0);
    push_data(3, 2);
    wait_words("s6", 3, 200);
    repeat (10) tick();
    check_words("s6");
    chk("s6_idle", 32'(bus.BUSY), 32'h0);

    chk("onehot_req", 32'(onehot_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ro_scheduler.md
# ro_scheduler

Readout scheduler for the multi-channel digitizer. It sits between the per-channel sample buffers and the global readout FIFO. It latches channel triggers into a pending set and picks one pending channel at a time with a round-robin arbiter. For each serviced channel it writes one header word, {0, channel, bunch-crossing}, then drains `howmany` samples from that channel's buffer into the FIFO, throttled by FIFO almost-full. It replaces fixed highest-channel-wins selection, so simultaneous or back-to-back triggers on several channels are all read out and none is starved.

## Interface
- `CHAN`, 8: number of channels, 1..8. The channel field is always 3 bits.
- `WIDTH`, 16: sample and FIFO word width. It is fixed at 16 because the header layout depends on it.
- `SIZE`, 8: width of `howmany`.
- `CLK` input 1: system clock (CK50 domain).
- `RST` input 1: reset, asynchronous, active-low.
- `TRIGGER` input CHAN: per-channel trigger, sampled on every rising edge.
- `howmany` input SIZE: number of samples to read per trigger, captured at grant.
- `BC` input 12: bunch-crossing counter, captured at grant.
- `CH_DATA` input WIDTH*CHAN: buffer outputs. Each is valid one cycle after its `RD_REQUEST` bit.
- `FIFO_AFULL` input 1: global FIFO has 3 or fewer free words.
- `RD_REQUEST` output CHAN: one-hot read strobe to the serviced channel.
- `FIFO_DIN` output WIDTH: word to the global FIFO.
- `FIFO_WR_EN` output 1: FIFO write strobe.
- `CUR_CHAN` output 3: channel currently being serviced.
- `BUSY` output 1: high in every state except IDLE.
- `DROP_CNT` output 8: count of dropped triggers, saturating.

## Operation
- **Pending set.** `pend[i]` is set on any cycle where `TRIGGER[i]` is high.
  - A trigger on a channel whose bit is already set is dropped. `DROP_CNT` increments and saturates at 255.
  - In the cycle a bit is cleared, a trigger on the same channel wins: the bit stays set and the trigger is not counted as a drop.
- **IDLE.**
  - If `pend` is nonzero, the arbiter grants the first set bit above the last-served channel, wrapping modulo CHAN.
  - At the grant the block latches `CUR_CHAN`, `BC` and `howmany` into the counter `cnt`, then moves to HDR.
  - After reset the last-served channel is CHAN-1, so channel 0 has first priority.
- **HDR.**
  - Waits while `FIFO_AFULL` is high.
  - Otherwise registers the header {1'b0, CUR_CHAN, BC_latched} onto `FIFO_DIN` with `FIFO_WR_EN` high.
  - Next state is DATA if `cnt` ≠ 0, otherwise CLR.
- **DATA.**
  - Each cycle where `FIFO_AFULL` is low, asserts `RD_REQUEST[CUR_CHAN]` (registered) and decrements `cnt`.
  - After the request that brings `cnt` to 0, moves to DRAIN.
- **Data pipeline.** `CH_DATA` of `CUR_CHAN`, delayed one cycle after the request, is registered onto `FIFO_DIN` with `FIFO_WR_EN` high.
- **DRAIN.** Waits 2 cycles until the pipeline is empty, then moves to CLR.
- **CLR.** Clears `pend[CUR_CHAN]`, updates last-served to `CUR_CHAN`, moves to IDLE.
- **Words per trigger.** Exactly 1 + `howmany`, or 2 + `howmany` with the trailer feature enabled. The FIFO never overflows.
- **Reset.** An assertion at any point, mid-burst included, returns the block to IDLE. All of these are 0 during and after reset: `RD_REQUEST`, `FIFO_WR_EN`, `FIFO_DIN`, `CUR_CHAN`, `BUSY`, `DROP_CNT`, `pend`, `cnt`.

## Timing
- **Nominal sequence.** `TRIGGER[i]` is high in cycle c0.
  - c1: grant in IDLE.
  - c2: HDR.
  - c3: header `FIFO_WR_EN`.
  - c3..c3+N-1: `RD_REQUEST` high, with N = `howmany`.
  - c5..c4+N: data writes.
  - Back in IDLE at c7+N, so the next grant is at c7+N at the earliest.
- **Throttle.** `FIFO_AFULL` is sampled combinationally in HDR and DATA. Up to 2 words are in flight, hence the 3-word threshold.
- **Request spacing.** `RD_REQUEST` never goes high in two different channels; it is one-hot or zero.
- **Input sampling.** `howmany` and `BC` may change freely after the grant.

## Configuration
- **`RO_TRAILER_EN` defined.**
  - After DRAIN the block enters a TRL state.
  - TRL waits for `!FIFO_AFULL`, then writes the trailer {1'b1, CUR_CHAN, 4'b0, 8 LSBs of `howmany` as latched} before CLR.
- **`RO_TRAILER_EN` undefined.** No TRL state and no trailer word; everything else is identical.

## Structure
- **Package `digi_pkg`:**
  - state enum: IDLE, HDR, DATA, DRAIN, TRL, CLR;
  - `HDR_MARK` = 1'b0 and `TRL_MARK` = 1'b1;
  - `BC_W` = 12 and `CH_W` = 3.
- **Sub-module `rr_arbiter`:**
  - parameter `CHAN`; inputs `req[CHAN-1:0]` and `last[2:0]`;
  - outputs `gnt_idx[2:0]` and `gnt_valid`;
  - purely combinational rotate-and-priority-encode.

## Test plan
- **Single trigger.** `TRIGGER[2]` pulse, `howmany`=4, `BC`=0x123 → `FIFO_DIN` 0x2123, then 4 words of ch2 data, with `RD_REQUEST`=8'h04 for exactly 4 cycles.
- **Simultaneous triggers.** `TRIGGER`=8'b1000_0101 in the same cycle after reset → service order ch0, ch2, ch7. Headers 0x0xxx, 0x2xxx, 0x7xxx; 3×(1+N) words total.
- **Back-pressure.** Hold `FIFO_AFULL` high for 10 cycles mid-DATA with `howmany`=16 → no `RD_REQUEST` during the stall, resume afterwards, still exactly 17 words written.
- **Drop.** Retrigger ch1 during its own burst → `DROP_CNT`=1, ch1 serviced once. A retrigger in the CLR cycle → ch1 serviced again, `DROP_CNT` unchanged.
- **Zero samples.** `howmany`=0 → header only (plus trailer 0x8000|chan<<12 when `RO_TRAILER_EN` is defined), then IDLE.
- **Reset mid-burst.** Assert `RST` low during DATA → all outputs 0 the same cycle. After release the block is idle and a new trigger is serviced cleanly.
